// File: rtl/foobar_arbiter.sv
// Round-robin arbiter that time-shares one foobar datapath among NUM_REQ requesters.
// Grants one requester, holds its operand on dp_a for LATENCY cycles, then returns dp_b tagged with the index.
module foobar_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] req_a,
   output logic [NUM_REQ-1:0] gnt,
   output logic               dp_a,
   input  logic               dp_b,
   output logic               busy,
   output logic               done,
   output logic [ID_W-1:0]    done_id,
   output logic               done_b
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned EXT_W = ID_W + 1;
   localparam logic [EXT_W-1:0] NUM_REQ_EXT = EXT_W'(NUM_REQ);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    ptr_nxt;
   logic [ID_W-1:0]    cur_id;
   logic [ID_W-1:0]    cur_id_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [NUM_REQ-1:0] gnt_nxt;
   logic               dp_a_nxt;
   logic               busy_nxt;
   logic               done_nxt;
   logic [ID_W-1:0]    done_id_nxt;
   logic               done_b_nxt;

   logic               any_req;
   logic               last;
   logic [NUM_REQ-1:0] rot;
   logic [ID_W-1:0]    off;
   logic               found;
   logic [EXT_W-1:0]   win_sum;
   logic [EXT_W-1:0]   inc_sum;
   logic [ID_W-1:0]    win;
   logic               win_a;

   assign any_req = |req;
   assign last    = (cnt == CNT_W'(1));

   // Rotate req so bit 0 is the requester at ptr, take the lowest set bit, rotate back.
   always_comb begin : pick
      rot   = NUM_REQ'({req, req} >> ptr);
      off   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && rot[0]) begin
            found = 1'b1;
            off   = ID_W'(i);
         end
         rot = rot >> 1;
      end
      win_sum = {1'b0, ptr} + {1'b0, off};
      if (win_sum >= NUM_REQ_EXT) begin
         win_sum = win_sum - NUM_REQ_EXT;
      end
      win     = win_sum[ID_W-1:0];
      inc_sum = {1'b0, win} + EXT_W'(1);
      if (inc_sum >= NUM_REQ_EXT) begin
         inc_sum = '0;
      end
      win_a = 1'(req_a >> win);
   end

   always_ff @(posedge clock or negedge reset_n) begin : state_reg
      if (!reset_n) begin
         state   <= IDLE;
         ptr     <= '0;
         cur_id  <= '0;
         cnt     <= '0;
         gnt     <= '0;
         dp_a    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= '0;
         done_b  <= 1'b0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         cur_id  <= cur_id_nxt;
         cnt     <= cnt_nxt;
         gnt     <= gnt_nxt;
         dp_a    <= dp_a_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         done_id <= done_id_nxt;
         done_b  <= done_b_nxt;
      end
   end

   always_comb begin : next_state
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = WAIT;
         WAIT:    if (last)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs; dp_a and the result fields hold unless rewritten.
   always_comb begin : outputs
      gnt_nxt     = '0;
      dp_a_nxt    = dp_a;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      done_id_nxt = done_id;
      done_b_nxt  = done_b;
      cur_id_nxt  = cur_id;
      cnt_nxt     = cnt;
      ptr_nxt     = ptr;
      case (state)
         IDLE: begin
            if (any_req) begin
               gnt_nxt    = NUM_REQ'(1) << win;
               dp_a_nxt   = win_a;
               cur_id_nxt = win;
               cnt_nxt    = CNT_W'(LATENCY);
               ptr_nxt    = inc_sum[ID_W-1:0];
               busy_nxt   = 1'b1;
            end
         end
         WAIT: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (last) begin
               done_b_nxt  = dp_b;
               done_id_nxt = cur_id;
               done_nxt    = 1'b1;
               busy_nxt    = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule
